cond_unit: RTL and testbench

- Decode→execute boundary stage directly downstream of the instruction decoder.
- Captures the decoder's control outputs and the instruction condition field into an execute-stage pipeline register, with stall and flush.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition code against it.
- Produces the condition-gated pcs/reg_w/mem_w strobes consumed by the register file, data memory and PC mux, plus the carry for ADC.

---
 rtl/cond_unit.sv | 106 ++++++++++
 tb/tb_cond_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Decode->execute pipeline register with NZCV flag register and condition evaluation.
// Produces condition-gated write/branch strobes for the execute-stage instruction.
module cond_unit #(
    parameter int COND_W = 4,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [COND_W-1:0] cond_d,
    input  logic              pcs_d,
    input  logic              reg_w_d,
    input  logic              mem_w_d,
    input  logic [1:0]        flag_w_d,
    input  logic              no_write_d,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              pcs_e,
    output logic              reg_w_e,
    output logic              mem_w_e,
    output logic              cond_ex,
    output logic [FLAG_W-1:0] flags,
    output logic              carry_in
);

    typedef struct packed {
        logic              valid;
        logic [COND_W-1:0] cond;
        logic              pcs;
        logic              reg_w;
        logic              mem_w;
        logic [1:0]        flag_w;
        logic              no_write;
    } ex_t;

    ex_t               ex_q, ex_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              cond_pass;
    logic              commit;
    logic              n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (ex_q.cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = ~z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = ~c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = ~n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = ~v_f;
            4'b1000: cond_pass = c_f & ~z_f;
            4'b1001: cond_pass = ~c_f | z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = ~z_f & (n_f == v_f);
            4'b1101: cond_pass = z_f | (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign cond_ex  = ex_q.valid & cond_pass;
    assign commit   = cond_ex & ~stall;
    assign pcs_e    = commit & ex_q.pcs;
    assign reg_w_e  = commit & ex_q.reg_w & ~ex_q.no_write;
    assign mem_w_e  = commit & ex_q.mem_w;
    assign flags    = flags_q;
    assign carry_in = c_f;

    // The E instruction commits even when flush squashes the incoming one.
    always_comb begin
        flags_d = flags_q;
        if (commit) begin
            if (ex_q.flag_w[1]) flags_d[3:2] = alu_flags[3:2];
            if (ex_q.flag_w[0]) flags_d[1:0] = alu_flags[1:0];
        end

        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d.valid    = 1'b1;
            ex_d.cond     = cond_d;
            ex_d.pcs      = pcs_d;
            ex_d.reg_w    = reg_w_d;
            ex_d.mem_w    = mem_w_d;
            ex_d.flag_w   = flag_w_d;
            ex_d.no_write = no_write_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q    <= '0;
            flags_q <= '0;
        end else begin
            ex_q    <= ex_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios with literal expectations plus random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       rst_n, stall, flush;
    logic [3:0] cond_d;
    logic       pcs_d, reg_w_d, mem_w_d, no_write_d;
    logic [1:0] flag_w_d;
    logic [3:0] alu_flags;
    logic       pcs_e, reg_w_e, mem_w_e, cond_ex, carry_in;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    cond_unit #(.COND_W(4), .FLAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .cond_d(cond_d), .pcs_d(pcs_d), .reg_w_d(reg_w_d), .mem_w_d(mem_w_d),
        .flag_w_d(flag_w_d), .no_write_d(no_write_d), .alu_flags(alu_flags),
        .pcs_e(pcs_e), .reg_w_e(reg_w_e), .mem_w_e(mem_w_e), .cond_ex(cond_ex),
        .flags(flags), .carry_in(carry_in)
    );

    // Model: the instruction sitting in E and the architectural flags.
    bit       m_valid, m_pcs, m_regw, m_memw, m_nw;
    bit [3:0] m_cond, m_flags;
    bit [1:0] m_fw;

    // ARM-style: odd codes are the inverse of the even code below them.
    function automatic bit cpass(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit commit;
        bit [3:0] nf;
        if (!rst_n) begin
            {m_valid, m_pcs, m_regw, m_memw, m_nw} <= '0;
            m_cond <= '0; m_fw <= '0; m_flags <= '0;
        end else begin
            commit = m_valid && cpass(m_cond, m_flags) && !stall;
            nf = m_flags;
            if (commit && m_fw[1]) nf[3:2] = alu_flags[3:2];
            if (commit && m_fw[0]) nf[1:0] = alu_flags[1:0];
            m_flags <= nf;
            if (flush) begin
                {m_valid, m_pcs, m_regw, m_memw, m_nw} <= '0;
                m_cond <= '0; m_fw <= '0;
            end else if (!stall) begin
                m_valid <= 1'b1; m_cond <= cond_d; m_pcs <= pcs_d;
                m_regw <= reg_w_d; m_memw <= mem_w_d; m_fw <= flag_w_d; m_nw <= no_write_d;
            end
        end
    end

    always @(negedge clk) begin
        bit cx, cm;
        if (chk_en) begin
            cx = m_valid && cpass(m_cond, m_flags);
            cm = cx && !stall;
            chk("cond_ex", {3'b0, cond_ex}, {3'b0, cx});
            chk("pcs_e", {3'b0, pcs_e}, {3'b0, cm && m_pcs});
            chk("reg_w_e", {3'b0, reg_w_e}, {3'b0, cm && m_regw && !m_nw});
            chk("mem_w_e", {3'b0, mem_w_e}, {3'b0, cm && m_memw});
            chk("flags", flags, m_flags);
            chk("carry_in", {3'b0, carry_in}, {3'b0, m_flags[1]});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit [3:0] c, input bit p, input bit rw, input bit mw,
                        input bit [1:0] fw, input bit nw);
        cond_d = c; pcs_d = p; reg_w_d = rw; mem_w_d = mw; flag_w_d = fw; no_write_d = nw;
        tick();
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0; alu_flags = 0;
        cond_d = 4'b1110; pcs_d = 0; reg_w_d = 1; mem_w_d = 0; flag_w_d = 0; no_write_d = 0;
        tick(); chk_en = 1; tick();
        @(negedge clk);
        chk("rst reg_w_e", {3'b0, reg_w_e}, 4'd0);
        chk("rst cond_ex", {3'b0, cond_ex}, 4'd0);
        chk("rst flags", flags, 4'b0000);
        rst_n = 1;

        // Flag set, then EQ / NE
        load(4'b1110, 0, 0, 0, 2'b11, 0); alu_flags = 4'b0100;
        @(negedge clk); chk("set cond_ex", {3'b0, cond_ex}, 4'd1);
        load(4'b0000, 0, 1, 0, 2'b00, 0); alu_flags = 4'b0000;
        @(negedge clk); chk("EQ reg_w_e", {3'b0, reg_w_e}, 4'd1); chk("EQ flags", flags, 4'b0100);
        load(4'b0001, 0, 1, 0, 2'b00, 0);
        @(negedge clk); chk("NE reg_w_e", {3'b0, reg_w_e}, 4'd0); chk("NE flags", flags, 4'b0100);

        // CMP: no register write, flags updated; LT then GE
        load(4'b1110, 0, 1, 0, 2'b11, 1); alu_flags = 4'b1000;
        @(negedge clk); chk("CMP reg_w_e", {3'b0, reg_w_e}, 4'd0); chk("CMP cond_ex", {3'b0, cond_ex}, 4'd1);
        load(4'b1011, 0, 0, 0, 2'b00, 0);
        @(negedge clk); chk("CMP flags", flags, 4'b1000); chk("LT cond_ex", {3'b0, cond_ex}, 4'd1);
        load(4'b1010, 0, 0, 0, 2'b00, 0);
        @(negedge clk); chk("GE cond_ex", {3'b0, cond_ex}, 4'd0);

        // Partial flag write keeps C,V
        load(4'b1110, 0, 0, 0, 2'b11, 0); alu_flags = 4'b1111;
        load(4'b1110, 0, 0, 0, 2'b10, 0); alu_flags = 4'b0000;
        @(negedge clk); chk("pre flags", flags, 4'b1111);
        load(4'b1110, 0, 1, 0, 2'b00, 0);
        @(negedge clk); chk("partial flags", flags, 4'b0011); chk("ADC carry_in", {3'b0, carry_in}, 4'd1);

        // Stall holds a store for 3 cycles, then one commit
        load(4'b1110, 0, 0, 1, 2'b00, 0);
        stall = 1; cond_d = 4'b1111; mem_w_d = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("stall mem_w_e", {3'b0, mem_w_e}, 4'd0);
            tick();
        end
        stall = 0;
        @(negedge clk); chk("unstall mem_w_e", {3'b0, mem_w_e}, 4'd1);
        tick();
        @(negedge clk); chk("after mem_w_e", {3'b0, mem_w_e}, 4'd0);

        // Flush alongside a committing branch
        load(4'b1110, 1, 0, 0, 2'b00, 0);
        flush = 1; pcs_d = 1;
        @(negedge clk); chk("flush pcs_e", {3'b0, pcs_e}, 4'd1);
        tick(); flush = 0; pcs_d = 0;
        @(negedge clk); chk("bubble pcs_e", {3'b0, pcs_e}, 4'd0); chk("bubble cond_ex", {3'b0, cond_ex}, 4'd0);

        // Reset during a stalled flag-writing instruction
        load(4'b1110, 0, 0, 0, 2'b11, 0); alu_flags = 4'b1111;
        stall = 1; rst_n = 0; tick(); rst_n = 1; stall = 0;
        @(negedge clk); chk("rst-stall flags", flags, 4'b0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            cond_d     = 4'($urandom);
            pcs_d      = 1'($urandom);
            reg_w_d    = 1'($urandom);
            mem_w_d    = 1'($urandom);
            flag_w_d   = 2'($urandom);
            no_write_d = 1'($urandom);
            alu_flags  = 4'($urandom);
            tick();
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
